// File: rtl/peri_ledpwm.sv
// peri_ledpwm: Wishbone-controlled LED driver with per-channel PWM duty and
// a bus-activity display mode. Registers:
//   0x0 CTRL     bit0 MODE (0 = PWM, 1 = ACTIVITY), bit1 CLR (write-1, reads 0)
//   0x1 PRESCALE tick divider for the PWM phase counter
//   0x2.. DUTY[i] one per LED, low PwmBits significant
module peri_ledpwm #(
  parameter int unsigned Leds    = 8,
  parameter int unsigned PwmBits = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [3:0]      wb_adr_i,
  input  logic [7:0]      wb_dat_i,
  output logic [7:0]      wb_dat_o,
  output logic            wb_ack_o,
  output logic [Leds-1:0] blinkenlights_o
);

  typedef enum logic {
    MODE_PWM = 1'b0,
    MODE_ACT = 1'b1
  } mode_e;

  mode_e              mode;
  logic [7:0]         prescale;
  logic [7:0]         presc_cnt;
  logic [PwmBits-1:0] phase;
  logic [PwmBits-1:0] duty [Leds];
  logic [Leds-1:0]    evt_cnt;
  logic [Leds-1:0]    pwm_next;
  logic [7:0]         rdata;

  logic req;
  logic wr;
  logic ctrl_wr;
  logic clr_wr;
  logic presc_wr;
  logic tick;

  // A request is only accepted while no ack is outstanding, so acks never
  // appear on two consecutive cycles.
  assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr       = req & wb_we_i;
  assign ctrl_wr  = wr & (wb_adr_i == 4'h0);
  assign clr_wr   = ctrl_wr & wb_dat_i[1];
  assign presc_wr = wr & (wb_adr_i == 4'h1);
  assign tick     = (presc_cnt == prescale);

  // Read data mux; unmapped addresses read as zero.
  always_comb begin
    rdata = '0;
    if (wb_adr_i == 4'h0) begin
      rdata = {7'b0, (mode == MODE_ACT)};
    end else if (wb_adr_i == 4'h1) begin
      rdata = prescale;
    end else begin
      for (int unsigned i = 0; i < Leds; i++) begin
        if (wb_adr_i == 4'(i + 2)) rdata = 8'(duty[i]);
      end
    end
  end

  // Bus response: ack one cycle after the request, read data captured with it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req && !wb_we_i) ? rdata : '0;
    end
  end

  // Configuration registers; writes commit on the request cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode     <= MODE_PWM;
      prescale <= '0;
      for (int unsigned i = 0; i < Leds; i++) duty[i] <= '0;
    end else begin
      if (ctrl_wr)  mode     <= mode_e'(wb_dat_i[0]);
      if (presc_wr) prescale <= wb_dat_i;
      for (int unsigned i = 0; i < Leds; i++) begin
        if (wr && (wb_adr_i == 4'(i + 2))) duty[i] <= wb_dat_i[PwmBits-1:0];
      end
    end
  end

  // Prescaler and PWM phase; CLR zeroes both, a PRESCALE write restarts only
  // the prescaler while the phase keeps its normal progression.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_cnt <= '0;
      phase     <= '0;
    end else if (clr_wr) begin
      presc_cnt <= '0;
      phase     <= '0;
    end else begin
      if (presc_wr || tick) presc_cnt <= '0;
      else                  presc_cnt <= presc_cnt + 8'd1;
      if (tick) phase <= phase + PwmBits'(1);
    end
  end

  // Bus activity counter; CLR overrides the increment of its own request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      evt_cnt <= '0;
    end else if (clr_wr) begin
      evt_cnt <= '0;
    end else if (req) begin
      evt_cnt <= evt_cnt + Leds'(1);
    end
  end

  // PWM compare; full-scale duty is forced on so the LED never blinks off.
  always_comb begin
    pwm_next = '0;
    for (int unsigned i = 0; i < Leds; i++) begin
      pwm_next[i] = (duty[i] == '1) || (phase < duty[i]);
    end
  end

  // Registered LED drive selected by mode.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blinkenlights_o <= '0;
    end else begin
      blinkenlights_o <= (mode == MODE_ACT) ? evt_cnt : pwm_next;
    end
  end

endmodule

// File: tb/tb_peri_ledpwm.sv
// Directed scoreboard bench for peri_ledpwm: bus reads push their expected
// data, a monitor pops and compares on every ack.
module tb_peri_ledpwm;

  localparam int unsigned Leds    = 8;
  localparam int unsigned PwmBits = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cyc = 1'b0;
  logic            stb = 1'b0;
  logic            we  = 1'b0;
  logic [3:0]      adr = '0;
  logic [7:0]      dat = '0;
  logic [7:0]      dat_o;
  logic            ack;
  logic [Leds-1:0] leds;

  int n_vec = 0;
  int n_err = 0;
  int n_ack = 0;
  logic prev_ack = 1'b0;
  logic [Leds-1:0] mdl_evt = '0;
  logic [8:0] exp_q [$];

  peri_ledpwm #(.Leds(Leds), .PwmBits(PwmBits)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .wb_cyc_i       (cyc),
    .wb_stb_i       (stb),
    .wb_we_i        (we),
    .wb_adr_i       (adr),
    .wb_dat_i       (dat),
    .wb_dat_o       (dat_o),
    .wb_ack_o       (ack),
    .blinkenlights_o(leds)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every ack must match a queued expectation.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      n_ack++;
      chk("ack_back_to_back", 32'(prev_ack), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if (e[8]) chk("read_data", 32'(dat_o), 32'(e[7:0]));
      end
    end
    prev_ack = ack;
  end

  // One Wishbone transfer, starting and ending on a falling edge.
  task automatic xfer(input logic w, input logic [3:0] a, input logic [7:0] d,
                      input logic [7:0] exp_rd);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d;
    exp_q.push_back({~w, exp_rd});
    if (w && a == 4'h0 && d[1]) mdl_evt = '0;
    else                        mdl_evt = mdl_evt + Leds'(1);
    @(negedge clk);
    chk("ack_latency", 32'(ack), 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp_rd);
    xfer(1'b0, a, 8'h00, exp_rd);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    xfer(1'b1, a, d, 8'h00);
  endtask

  initial begin
    int c0, c1, c2, a0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", 32'(dat_o), 32'd0);
    rst = 1'b0;
    mdl_evt = '0;

    // Post-reset reads, first one on the very next edge
    rd(4'h0, 8'h00);
    rd(4'h1, 8'h00);
    rd(4'h2, 8'h00);
    chk("reset_leds_pwm", 32'(leds), 32'd0);

    // PWM with prescale 0
    wr(4'h1, 8'h00);
    wr(4'h2, 8'd64);
    wr(4'h3, 8'hFF);
    wr(4'h4, 8'h00);
    rd(4'h2, 8'd64);
    rd(4'h3, 8'hFF);
    c0 = 0; c1 = 0; c2 = 0;
    repeat (256) begin
      @(negedge clk);
      c0 += int'(leds[0]); c1 += int'(leds[1]); c2 += int'(leds[2]);
    end
    chk("pwm_led0_64", 32'(c0), 32'd64);
    chk("pwm_led1_full", 32'(c1), 32'd256);
    chk("pwm_led2_off", 32'(c2), 32'd0);

    // Prescale 3: phase steps every 4 cycles
    wr(4'h1, 8'h03);
    wr(4'h2, 8'h01);
    rd(4'h1, 8'h03);
    repeat (8) @(negedge clk);
    c0 = 0; c1 = 0;
    repeat (1024) begin
      @(negedge clk);
      c0 += int'(leds[0]); c1 += int'(leds[1]);
    end
    chk("presc_led0_4", 32'(c0), 32'd4);
    chk("presc_led1_full", 32'(c1), 32'd1024);

    // Unmapped addresses
    wr(4'hF, 8'h77);
    rd(4'hF, 8'h00);
    rd(4'hA, 8'h00);

    // Activity mode with clear, count to wrap
    wr(4'h0, 8'h03);
    chk("act_clr_leds", 32'(leds), 32'(mdl_evt));
    rd(4'h0, 8'h01);
    repeat (254) rd(4'h1, 8'h03);
    chk("act_ff", 32'(leds), 32'hFF);
    rd(4'h1, 8'h03);
    chk("act_wrap", 32'(leds), 32'h00);
    repeat (42) rd(4'h1, 8'h03);
    chk("act_2a", 32'(leds), 32'h2A);

    // Strobe without cycle: no ack, no state change
    stb = 1'b1; we = 1'b1; adr = 4'h0; dat = 8'h03;
    repeat (5) @(negedge clk);
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("stb_only_leds", 32'(leds), 32'h2A);

    // Clear while counter = 0x2A
    wr(4'h0, 8'h03);
    chk("clr_leds", 32'(leds), 32'h00);
    rd(4'hF, 8'h00);
    chk("after_clr_count", 32'(leds), 32'(mdl_evt));

    // Back-to-back strobe held 10 cycles
    a0 = n_ack;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'h1;
    repeat (5) begin
      exp_q.push_back({1'b1, 8'h03});
      mdl_evt = mdl_evt + Leds'(1);
    end
    repeat (10) @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("b2b_acks", 32'(n_ack - a0), 32'd5);
    chk("b2b_leds", 32'(leds), 32'(mdl_evt));

    // Reset in the middle of a write: no ack, write lost
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'h5; dat = 8'h55;
    #2 rst = 1'b1;
    #1 cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_leds", 32'(leds), 32'd0);
    rst = 1'b0;
    mdl_evt = '0;
    @(negedge clk);
    rd(4'h5, 8'h00);
    rd(4'h0, 8'h00);
    rd(4'h1, 8'h00);
    chk("midrst_pwm_leds", 32'(leds), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
